// File: rtl/anton_neopixel_apb_bridge.sv
// APB3 completer that turns each APB transfer into a single native-bus strobe
// for the neopixel register block and frame buffer.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 299
`endif

module anton_neopixel_apb_bridge #(
    parameter int unsigned BUFFER_END = `BUFFER_END_DEFAULT
) (
    input  logic        busClk,
    input  logic        busRstN,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [15:0] paddr,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut,
    output logic [7:0]  errCount
);

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        ERR  = 3'd4
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic               preadyNext;
    logic               pslverrNext;
    logic               busWriteNext;
    logic               busReadNext;
    logic [ADDR_W-1:0]  busAddrNext;
    logic [DATA_W-1:0]  busDataInNext;
    logic [CNT_W-1:0]   errCountNext;

    logic isReg;
    logic illegal;
    logic setupPhase;
    logic unusedBits;

    assign unusedBits = ^pwdata[31:8];

    // Address decode: register space is paddr[15]=1 with only four byte registers, index 3 read-only.
    assign isReg      = paddr[15];
    assign setupPhase = psel && !penable;
    assign illegal    = (paddr[1:0] != 2'b00)
                     || (!isReg && (32'(paddr[14:2]) > BUFFER_END))
                     || (isReg && (paddr[14:5] != 10'd0))
                     || (isReg && (paddr[4:2] > 3'd3))
                     || (isReg && pwrite && (paddr[4:2] == 3'd3));

    // Read data is forwarded straight from the target during the completing read cycle.
    assign prdata = (state == RD2) ? {24'd0, busDataOut} : 32'd0;

    always_comb begin
        stateNext     = state;
        preadyNext    = 1'b0;
        pslverrNext   = 1'b0;
        busWriteNext  = 1'b0;
        busReadNext   = 1'b0;
        busAddrNext   = busAddr;
        busDataInNext = busDataIn;
        errCountNext  = errCount;
        case (state)
            IDLE: begin
                if (setupPhase) begin
                    busAddrNext   = paddr[15:2];
                    busDataInNext = pwdata[7:0];
                    if (illegal) begin
                        stateNext   = ERR;
                        preadyNext  = 1'b1;
                        pslverrNext = 1'b1;
                        if (errCount != {CNT_W{1'b1}}) begin
                            errCountNext = errCount + CNT_W'(1);
                        end
                    end else if (pwrite) begin
                        stateNext    = WR;
                        busWriteNext = 1'b1;
                        preadyNext   = 1'b1;
                    end else begin
                        stateNext   = RD1;
                        busReadNext = 1'b1;
                    end
                end
            end
            RD1: begin
                if (psel) begin
                    stateNext  = RD2;
                    preadyNext = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            WR, RD2, ERR: stateNext = IDLE;
            default:      stateNext = IDLE;
        endcase
    end

    always_ff @(posedge busClk or negedge busRstN) begin
        if (!busRstN) begin
            state     <= IDLE;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            busWrite  <= 1'b0;
            busRead   <= 1'b0;
            busAddr   <= '0;
            busDataIn <= '0;
            errCount  <= '0;
        end else begin
            state     <= stateNext;
            pready    <= preadyNext;
            pslverr   <= pslverrNext;
            busWrite  <= busWriteNext;
            busRead   <= busReadNext;
            busAddr   <= busAddrNext;
            busDataIn <= busDataInNext;
            errCount  <= errCountNext;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
// Bench for the neopixel APB bridge: directed steps plus random transfers
// checked against an address-rule reference model and a simple native target.

module tb_anton_neopixel_apb_bridge;

    localparam int unsigned BUFFER_END = 299;

    logic        busClk;
    logic        busRstN;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;
    logic [7:0]  errCount;

    anton_neopixel_apb_bridge #(.BUFFER_END(BUFFER_END)) dut (
        .busClk(busClk), .busRstN(busRstN), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .busAddr(busAddr), .busDataIn(busDataIn),
        .busWrite(busWrite), .busRead(busRead), .busDataOut(busDataOut), .errCount(errCount)
    );

    initial busClk = 1'b0;
    always #5 busClk = ~busClk;

    int passCnt = 0;
    int failCnt = 0;
    int totalCnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Native target: three writable byte registers, a read-only status byte, frame buffer reads as FF.
    logic [7:0] tgtRegs [0:3];
    logic [7:0] statusVal;
    always @(posedge busClk or negedge busRstN) begin
        if (!busRstN) begin
            for (int i = 0; i < 4; i++) tgtRegs[i] <= 8'd0;
            busDataOut <= 8'd0;
        end else begin
            if (busWrite && busAddr[13] && busAddr[1:0] != 2'd3) tgtRegs[busAddr[1:0]] <= busDataIn;
            if (busRead) busDataOut <= busAddr[13] ? ((busAddr[1:0] == 2'd3) ? statusVal : tgtRegs[busAddr[1:0]]) : 8'hFF;
        end
    end

    typedef struct {
        bit         isWrite;
        logic [13:0] addr;
        logic [7:0]  data;
    } evT;
    evT evQ[$];

    // Strobe log, sampled mid-cycle; each cycle a strobe is high gives one entry.
    always @(negedge busClk) begin
        if (busWrite || busRead) begin
            chk("strobe_exclusive", 32'(busWrite && busRead), 32'd0);
            evQ.push_back('{busWrite, busAddr, busDataIn});
        end
    end

    // Reference model state
    logic [7:0] regModel [0:3];
    int unsigned errModel;

    function automatic bit modelIllegal(input bit wr, input int unsigned a);
        if (a % 4 != 0) return 1'b1;
        if (a < 32'h8000) return (a / 4) > BUFFER_END;
        return ((a - 32'h8000) / 4 > 3) || (wr && ((a - 32'h8000) / 4 == 3));
    endfunction

    task automatic apb(input bit wr, input logic [15:0] addr, input logic [7:0] data, input bit keepSel,
                       output logic [31:0] rdata, output logic err, output int waits);
        bit done;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = {24'($urandom), data};
        @(posedge busClk); #1;
        penable = 1'b1;
        waits   = 0;
        done    = 1'b0;
        rdata   = 32'hDEAD_BEEF;
        err     = 1'bx;
        for (int i = 0; i < 8 && !done; i++) begin
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                done  = 1'b1;
            end else begin
                waits++;
            end
            @(posedge busClk); #1;
        end
        if (!done) chk("pready_timeout", 32'd1, 32'd0);
        if (!keepSel) begin
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    task automatic xfer(input bit wr, input logic [15:0] addr, input logic [7:0] data, input bit keepSel,
                        input string tag);
        int unsigned a;
        int unsigned r;
        bit          expErr;
        logic [7:0]  expData;
        logic [31:0] rdata;
        logic        err;
        int          waits;
        int          q0;
        a       = 32'(addr);
        expErr  = modelIllegal(wr, a);
        r       = (a >= 32'h8000) ? (a - 32'h8000) / 4 : 0;
        expData = 8'h00;
        if (!expErr && !wr) expData = (a < 32'h8000) ? 8'hFF : ((r == 3) ? statusVal : regModel[r]);
        q0 = evQ.size();
        apb(wr, addr, data, keepSel, rdata, err, waits);
        chk({tag, "_slverr"}, 32'(err), 32'(expErr));
        chk({tag, "_waits"}, 32'(waits), (expErr || wr) ? 32'd0 : 32'd1);
        chk({tag, "_prdata"}, rdata, {24'd0, expData});
        chk({tag, "_strobes"}, 32'(evQ.size() - q0), expErr ? 32'd0 : 32'd1);
        if (!expErr && evQ.size() == q0 + 1) begin
            chk({tag, "_dir"}, 32'(evQ[$].isWrite), 32'(wr));
            chk({tag, "_addr"}, 32'(evQ[$].addr), a / 4);
            if (wr) chk({tag, "_wdata"}, 32'(evQ[$].data), 32'(data));
        end
        if (!expErr && wr && a >= 32'h8000) regModel[r] = data;
        if (expErr && errModel < 255) errModel++;
        chk({tag, "_errCount"}, 32'(errCount), errModel);
    endtask

    initial begin
        int q0;
        logic [15:0] ra;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'd0; pwdata = 32'd0;
        statusVal = 8'($urandom);
        for (int i = 0; i < 4; i++) regModel[i] = 8'd0;
        errModel = 0;

        busRstN = 1'b1;
        #2 busRstN = 1'b0;
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_strobes", 32'({busWrite, busRead}), 32'd0);
        chk("rst_busAddr", 32'(busAddr), 32'd0);
        chk("rst_busDataIn", 32'(busDataIn), 32'd0);
        chk("rst_errCount", 32'(errCount), 32'd0);
        @(posedge busClk); @(posedge busClk); #1;
        busRstN = 1'b1;
        @(posedge busClk); #1;

        // Basic write and read
        xfer(1'b1, 16'h0010, 8'h5A, 1'b0, "t1_write");
        xfer(1'b1, 16'h8008, 8'h13, 1'b0, "t2_setreg");
        xfer(1'b0, 16'h8008, 8'h00, 1'b0, "t2_read");

        // Error path and saturation
        xfer(1'b1, 16'h0002, 8'h77, 1'b0, "t3_misaligned");
        for (int i = 0; i < 300; i++) xfer(1'b1, 16'h0002, 8'($urandom), (i != 299), "t3_sat");
        chk("t3_saturated", 32'(errCount), 32'hFF);

        // Status register and buffer boundary
        xfer(1'b1, 16'h800C, 8'h11, 1'b0, "t4_wr_status");
        xfer(1'b0, 16'h800C, 8'h00, 1'b0, "t4_rd_status");
        xfer(1'b0, 16'(BUFFER_END * 4), 8'h00, 1'b0, "t4_rd_buf_end");
        xfer(1'b0, 16'((BUFFER_END + 1) * 4), 8'h00, 1'b0, "t4_rd_buf_over");
        xfer(1'b0, 16'h8010, 8'h00, 1'b0, "t4_rd_reg4");
        xfer(1'b0, 16'h8020, 8'h00, 1'b0, "t4_rd_regspace_hi");

        // Back-to-back write/read/write
        q0 = evQ.size();
        xfer(1'b1, 16'h8004, 8'hC3, 1'b1, "t5_w");
        xfer(1'b0, 16'h8004, 8'h00, 1'b1, "t5_r");
        xfer(1'b1, 16'h8000, 8'h3C, 1'b0, "t5_w2");
        chk("t5_total_strobes", 32'(evQ.size() - q0), 32'd3);

        // Access-phase signals seen in IDLE are ignored
        q0 = evQ.size();
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'hAB;
        repeat (3) @(posedge busClk);
        #1;
        chk("idle_penable_pready", 32'(pready), 32'd0);
        chk("idle_penable_strobes", 32'(evQ.size() - q0), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge busClk); #1;

        // Reset in the middle of a read
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h8000;
        @(posedge busClk); #1;
        chk("t6_busRead_before", 32'(busRead), 32'd1);
        busRstN = 1'b0;
        #1;
        chk("t6_busRead_rst", 32'(busRead), 32'd0);
        chk("t6_pready_rst", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) regModel[i] = 8'd0;
        errModel = 0;
        @(posedge busClk); @(posedge busClk); #1;
        busRstN = 1'b1;
        repeat (2) @(posedge busClk);
        #1;
        chk("t6_pready_after", 32'(pready), 32'd0);
        chk("t6_errCount_after", 32'(errCount), 32'd0);
        xfer(1'b0, 16'h8004, 8'h00, 1'b0, "t6_read_after");
        xfer(1'b0, 16'h800C, 8'h00, 1'b0, "t6_status_after");

        // Random transfers across all address classes
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: ra = 16'($urandom_range(0, BUFFER_END) * 4);
                1: ra = 16'($urandom_range(BUFFER_END + 1, 8191) * 4);
                2: ra = 16'(32'h8000 + $urandom_range(0, 3) * 4);
                3: ra = 16'(($urandom & 32'hFFFC) | $urandom_range(1, 3));
                4: ra = 16'(32'h8000 + $urandom_range(4, 8191) * 4);
                default: ra = 16'(32'h8000 + $urandom_range(0, 2) * 4);
            endcase
            xfer(1'($urandom), ra, 8'($urandom), (n != 79) && 1'($urandom), "rnd");
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
